cpu_adapter: RTL

CPU_ADAPTER -- requirements
Module: cpu_adapter

---
 rtl/cpu_adapter_pkg.sv | 35 +++
 rtl/cpu_adapter_extract.sv | 24 ++
 rtl/cpu_adapter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_adapter_pkg.sv
// Shared encodings for the CPU load adapter: transfer sizes, byte lengths, FSM states.
package cpu_adapter_pkg;

  localparam logic [1:0] SZ_WORD     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_BYTE     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

  localparam logic [2:0] LEN_WORD = 3'd4;
  localparam logic [2:0] LEN_HALF = 3'd2;
  localparam logic [2:0] LEN_BYTE = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE2,
    ST_WAIT,
    ST_OUT
  } state_e;

  function automatic logic [2:0] size_len(input logic [1:0] sz);
    case (sz)
      SZ_HALF: return LEN_HALF;
      SZ_BYTE: return LEN_BYTE;
      default: return LEN_WORD;
    endcase
  endfunction

  // True when the last byte of the load falls into the following 64-bit word.
  function automatic logic spans_word(input logic [2:0] off, input logic [1:0] sz);
    logic [3:0] last;
    last = {1'b0, off} + {1'b0, size_len(sz)} - 4'd1;
    return last > 4'd7;
  endfunction

endpackage

// File: rtl/cpu_adapter_extract.sv
// Picks bytes off..off+len-1 out of a big-endian 128-bit word pair and zero-extends them.
module cpu_adapter_extract
  import cpu_adapter_pkg::*;
(
  input  logic [127:0] pair,
  input  logic [2:0]   off,
  input  logic [1:0]   sz,
  output logic [31:0]  data
);

  logic [127:0] shifted;
  logic [31:0]  top;

  always_comb begin
    shifted = pair << {off, 3'b000};
    top     = shifted[127:96];
    case (sz)
      SZ_HALF: data = {16'h0000, top[31:16]};
      SZ_BYTE: data = {24'h000000, top[31:24]};
      default: data = top;
    endcase
  end

endmodule

// File: rtl/cpu_adapter.sv
// CPU load adapter: resizes byte/half/word loads from a 64-bit packet memory,
// with a one-word read cache and support for loads that straddle two words.
module cpu_adapter
  import cpu_adapter_pkg::*;
#(
  parameter int BYTE_ADDR_WIDTH = 12,
  parameter int MEM_LAT         = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BYTE_ADDR_WIDTH-1:0] byte_rd_addr,
  input  logic                       cpu_rd_en,
  input  logic [1:0]                 transfer_sz,
  input  logic                       cache_inv,
  output logic [31:0]                resized_mem_data,
  output logic                       resized_mem_data_vld,
  output logic [BYTE_ADDR_WIDTH-4:0] word_rd_addr,
  output logic                       mem_rd_en,
  input  logic [63:0]                mem_rdata
);

  localparam int WW = BYTE_ADDR_WIDTH - 3;

  state_e         state_q, state_d;
  logic [WW-1:0]  w_q, w_d;
  logic [2:0]     off_q, off_d;
  logic [1:0]     sz_q, sz_d;
  logic           span_q, span_d;
  logic           mem_rd_en_q, mem_rd_en_d;
  logic [WW-1:0]  word_rd_addr_q, word_rd_addr_d;
  logic           mem_slot_q, mem_slot_d;
  logic [MEM_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [MEM_LAT-1:0] slot_pipe_q, slot_pipe_d;
  logic [127:0]   pair_q, pair_d;
  logic [WW-1:0]  cache_tag_q, cache_tag_d;
  logic [63:0]    cache_data_q, cache_data_d;
  logic           cache_vld_q, cache_vld_d;
  logic           inv_seen_q, inv_seen_d;
  logic [31:0]    data_q, data_d;
  logic           vld_q, vld_d;

  logic [WW-1:0]  acc_w;
  logic [2:0]     acc_off;
  logic           acc_span;
  logic           acc_hit;
  logic           cap, cap_slot, cap_last;
  logic [127:0]   pair_cap;
  logic [127:0]   ext_pair;
  logic [2:0]     ext_off;
  logic [1:0]     ext_sz;
  logic [31:0]    ext_data;

  assign acc_w    = byte_rd_addr[BYTE_ADDR_WIDTH-1:3];
  assign acc_off  = byte_rd_addr[2:0];
  assign acc_span = spans_word(acc_off, transfer_sz);
  // An invalidate arriving with the request already hides the old packet's word.
  assign acc_hit  = cache_vld_q && !cache_inv && (cache_tag_q == acc_w);

  assign cap      = rd_pipe_q[MEM_LAT-1];
  assign cap_slot = slot_pipe_q[MEM_LAT-1];
  assign cap_last = cap && (cap_slot == span_q);

  always_comb begin
    pair_cap = pair_q;
    if (cap) begin
      if (cap_slot) pair_cap[63:0]   = mem_rdata;
      else          pair_cap[127:64] = mem_rdata;
    end
  end

  always_comb begin
    if (state_q == ST_IDLE) begin
      ext_pair = {cache_data_q, 64'h0};
      ext_off  = acc_off;
      ext_sz   = transfer_sz;
    end else begin
      ext_pair = pair_cap;
      ext_off  = off_q;
      ext_sz   = sz_q;
    end
  end

  cpu_adapter_extract u_extract (
    .pair (ext_pair),
    .off  (ext_off),
    .sz   (ext_sz),
    .data (ext_data)
  );

  always_comb begin
    state_d        = state_q;
    w_d            = w_q;
    off_d          = off_q;
    sz_d           = sz_q;
    span_d         = span_q;
    mem_rd_en_d    = 1'b0;
    word_rd_addr_d = word_rd_addr_q;
    mem_slot_d     = mem_slot_q;
    pair_d         = cap ? pair_cap : pair_q;
    cache_tag_d    = cache_tag_q;
    cache_data_d   = cache_data_q;
    cache_vld_d    = cache_vld_q && !cache_inv;
    inv_seen_d     = inv_seen_q || cache_inv;
    data_d         = data_q;
    vld_d          = 1'b0;

    rd_pipe_d      = rd_pipe_q;
    slot_pipe_d    = slot_pipe_q;
    rd_pipe_d[0]   = mem_rd_en_q;
    slot_pipe_d[0] = mem_slot_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      rd_pipe_d[i]   = rd_pipe_q[i-1];
      slot_pipe_d[i] = slot_pipe_q[i-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (cpu_rd_en && !vld_q) begin
          w_d        = acc_w;
          off_d      = acc_off;
          sz_d       = transfer_sz;
          span_d     = acc_span;
          inv_seen_d = 1'b0;
          if (!acc_span && acc_hit) begin
            data_d  = ext_data;
            vld_d   = 1'b1;
            state_d = ST_OUT;
          end else if (acc_span && acc_hit) begin
            pair_d         = {cache_data_q, 64'h0};
            mem_rd_en_d    = 1'b1;
            word_rd_addr_d = acc_w + 1'b1;
            mem_slot_d     = 1'b1;
            state_d        = ST_WAIT;
          end else begin
            mem_rd_en_d    = 1'b1;
            word_rd_addr_d = acc_w;
            mem_slot_d     = 1'b0;
            state_d        = acc_span ? ST_ISSUE2 : ST_WAIT;
          end
        end
      end
      ST_ISSUE2: begin
        mem_rd_en_d    = 1'b1;
        word_rd_addr_d = w_q + 1'b1;
        mem_slot_d     = 1'b1;
        state_d        = ST_WAIT;
      end
      ST_WAIT: begin
        if (cap_last) begin
          data_d       = ext_data;
          vld_d        = 1'b1;
          cache_tag_d  = span_q ? w_q + 1'b1 : w_q;
          cache_data_d = mem_rdata;
          cache_vld_d  = !(inv_seen_q || cache_inv);
          state_d      = ST_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      w_q            <= '0;
      off_q          <= '0;
      sz_q           <= '0;
      span_q         <= 1'b0;
      mem_rd_en_q    <= 1'b0;
      word_rd_addr_q <= '0;
      mem_slot_q     <= 1'b0;
      rd_pipe_q      <= '0;
      slot_pipe_q    <= '0;
      pair_q         <= '0;
      cache_tag_q    <= '0;
      cache_data_q   <= '0;
      cache_vld_q    <= 1'b0;
      inv_seen_q     <= 1'b0;
      data_q         <= '0;
      vld_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      w_q            <= w_d;
      off_q          <= off_d;
      sz_q           <= sz_d;
      span_q         <= span_d;
      mem_rd_en_q    <= mem_rd_en_d;
      word_rd_addr_q <= word_rd_addr_d;
      mem_slot_q     <= mem_slot_d;
      rd_pipe_q      <= rd_pipe_d;
      slot_pipe_q    <= slot_pipe_d;
      pair_q         <= pair_d;
      cache_tag_q    <= cache_tag_d;
      cache_data_q   <= cache_data_d;
      cache_vld_q    <= cache_vld_d;
      inv_seen_q     <= inv_seen_d;
      data_q         <= data_d;
      vld_q          <= vld_d;
    end
  end

  assign resized_mem_data     = data_q;
  assign resized_mem_data_vld = vld_q;
  assign word_rd_addr         = word_rd_addr_q;
  assign mem_rd_en            = mem_rd_en_q;

endmodule
